delay_index_controller: RTL and testbench
=========================================

# delay_index_controller

Sequences updates to the per-channel read-delay indices that feed the beamformer's `channel_buffer` instances. An MCU-facing valid/ready write port fills a shadow bank of delay indices. A commit request copies the whole shadow bank into the active bank on the next frame boundary (falling edge of `ws`), so every channel switches steering delay on the same audio frame. The block sits between the `uio_in` configuration pins and the `read_index` inputs of `complete_dual_buffer`, replacing the bit-serial per-register shift loader.

## Interface
Parameters:
- `NUMBER_OF_CHANNELS`, 4, number of stereo I2S inputs; there are 2*`NUMBER_OF_CHANNELS` delay indices.
- `BUFFER_SIZE`, 16, depth of each channel buffer; `IDX_W` = $clog2(`BUFFER_SIZE`).
- `SEL_W`, $clog2(2*`NUMBER_OF_CHANNELS`), width of the index selector.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `ws`  in  1  frame word-select; a falling edge marks the frame boundary. Synchronous to `clk`, sampled directly with no synchronizer.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  controller can accept a write.
- `wr_sel`  in  `SEL_W`  target index (even = left, odd = right of channel `wr_sel`/2).
- `wr_delay`  in  `IDX_W`  delay value written to `shadow[wr_sel]`.
- `wr_commit`  in  1  qualifies the write; if set, a commit is requested after the write.
- `delay_index`  out  2*`NUMBER_OF_CHANNELS`*`IDX_W`  active bank, flattened; index k occupies bits [k*`IDX_W` +: `IDX_W`].
- `pending`  out  1  commit accepted, waiting for the frame boundary.
- `updated`  out  1  one-cycle pulse in the cycle after the active bank changes.

## Operation
- A transfer happens on a posedge where `wr_valid` && `wr_ready` are both high. On a transfer, `shadow[wr_sel]` <= `wr_delay`.
- `wr_sel` >= 2*`NUMBER_OF_CHANNELS`: the transfer completes (handshake honoured) and the write is discarded. A `wr_commit` on that transfer is still honoured.
- FSM states:
  - IDLE: `wr_ready`=1. A transfer with `wr_commit`=1 moves to PENDING.
  - PENDING: `wr_ready`=0, `pending`=1. On a detected `ws` fall, move to APPLY.
  - APPLY: the active bank takes the whole shadow bank. `wr_ready`=0. Move to IDLE next cycle.
- Fall detection: `ws_q` is `ws` registered. A fall is detected when `ws_q`=1 && `ws`=0.
- A commit transfer in the same cycle as a detected fall does not use that fall; it waits for the next one.
- The shadow bank persists across commits. Partial updates are allowed; unwritten entries keep their last value.
- Reset: shadow and active banks = 0, `ws_q` = 0, state = IDLE. `wr_ready`=1, `pending`=0, `updated`=0 from the first cycle after reset. Reset asserted in PENDING or APPLY discards the commit.

## Timing
- A write transferred at edge T is visible in shadow after T. It is not visible on `delay_index`.
- A commit transferred at edge T: `pending`=1 and `wr_ready`=0 from T+1.
- Fall detected at edge F (while in PENDING): state is APPLY after F. `delay_index` takes the new values and `pending` drops at F+1. `updated`=1 for exactly the cycle after F+1. `wr_ready` returns high after F+1.
- Worst-case commit latency is one ws period (64 `clk` cycles) plus 2 cycles.
- `delay_index` changes only at the APPLY-to-IDLE edge. It is stable for a full frame, ahead of the `channel_buffer` shift on the `ws` falling edge.

## Configuration
- `DELAY_READBACK_EN` defined: adds ports `rd_sel` (in, `SEL_W`) and `rd_shadow`/`rd_active` (out, `IDX_W` each). These are combinational reads of `shadow[rd_sel]` and active `[rd_sel]`. An out-of-range `rd_sel` reads 0.
- Not defined: these ports and their read muxes are absent. All other behaviour is identical.

## Structure
- Shared package `beamformer_pkg`: `NUMBER_OF_CHANNELS`, `BUFFER_SIZE`, `NUMBER_OF_BITS`, derived `IDX_W`/`SEL_W`, and the FSM state enum `dic_state_t` (IDLE, PENDING, APPLY).
- One sub-module, `frame_edge_detect`: registers `ws` and emits a one-cycle `fall` strobe. It is reused by other frame-synchronous controllers.

## Test plan
- Reset, then sample outputs: `delay_index`=0, `wr_ready`=1, `pending`=0, `updated`=0.
- Write sel=3, delay=5 (no commit), run 2 frames → `delay_index` unchanged (all 0). Then write sel=0, delay=9 with commit → after the next `ws` fall: index0=9, index3=5, `updated` pulses exactly once.
- Commit transfer in the same cycle as a `ws` fall → the bank updates only at the following fall, about 64 cycles later.
- Hold `wr_valid` high during PENDING → `wr_ready`=0 and the shadow is unchanged. The write lands in the cycle after `wr_ready` returns.
- Write sel=8 (out of range, N=4) with commit → no index changes, and the commit still applies at the fall with `updated` pulsing.
- Assert `reset` while in PENDING → `pending`=0, banks zero, and no `updated` pulse at the next fall.

Source files
------------

// File: rtl/beamformer_pkg.sv
// Shared beamformer definitions: array geometry, derived index widths and
// the delay-index controller state encoding.
package beamformer_pkg;

  localparam int NUMBER_OF_CHANNELS = 4;
  localparam int BUFFER_SIZE        = 16;
  localparam int NUMBER_OF_BITS     = 16;
  localparam int IDX_W              = $clog2(BUFFER_SIZE);
  localparam int SEL_W              = $clog2(2 * NUMBER_OF_CHANNELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } dic_state_t;

endpackage

// File: rtl/frame_edge_detect.sv
// Frame boundary detector: registers ws and flags a falling edge as a
// one-cycle strobe. ws is assumed synchronous to clk (no synchronizer).
module frame_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic ws,
  output logic fall
);

  logic ws_q_r;

  // Previous-cycle copy of ws for edge comparison
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_q_r <= 1'b0;
    end else begin
      ws_q_r <= ws;
    end
  end

  // Fall must be seen on the same edge where ws first reads low
  assign fall = ws_q_r & ~ws;

endmodule

// File: rtl/delay_index_controller.sv
// Delay index controller: MCU writes fill a shadow bank of per-channel read
// delays; a commit copies the whole shadow bank into the active bank on the
// next ws falling edge so all channels change steering on the same frame.
// Optional feature macro: DELAY_READBACK_EN (adds rd_sel/rd_shadow/rd_active).
module delay_index_controller #(
  parameter  int NUMBER_OF_CHANNELS = beamformer_pkg::NUMBER_OF_CHANNELS,
  parameter  int BUFFER_SIZE        = beamformer_pkg::BUFFER_SIZE,
  parameter  int SEL_W              = $clog2(2 * NUMBER_OF_CHANNELS),
  localparam int IDX_W              = $clog2(BUFFER_SIZE),
  localparam int NUM_IDX            = 2 * NUMBER_OF_CHANNELS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [IDX_W-1:0]           wr_delay,
  input  logic                       wr_commit,
  output logic [NUM_IDX*IDX_W-1:0]   delay_index,
  output logic                       pending,
`ifdef DELAY_READBACK_EN
  input  logic [SEL_W-1:0]           rd_sel,
  output logic [IDX_W-1:0]           rd_shadow,
  output logic [IDX_W-1:0]           rd_active,
`endif
  output logic                       updated
);

  import beamformer_pkg::*;

  dic_state_t               state_r;
  dic_state_t               state_next_s;
  logic                     fall_s;
  logic                     transfer_s;
  logic [IDX_W-1:0]         shadow_r [NUM_IDX];
  logic [NUM_IDX*IDX_W-1:0] active_r;
  logic                     wr_ready_r;
  logic                     pending_r;
  logic                     updated_r;

  frame_edge_detect u_frame_edge_detect (
    .clk   (clk),
    .reset (reset),
    .ws    (ws),
    .fall  (fall_s)
  );

  assign transfer_s = wr_valid & wr_ready_r;

  // Next-state logic; a fall seen while still IDLE is never used by a commit
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (transfer_s && wr_commit) begin
          state_next_s = PENDING;
        end else begin
          state_next_s = IDLE;
        end
      end
      PENDING: begin
        if (fall_s) begin
          state_next_s = APPLY;
        end else begin
          state_next_s = PENDING;
        end
      end
      APPLY:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register with status outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      wr_ready_r <= 1'b1;
      pending_r  <= 1'b0;
      updated_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wr_ready_r <= (state_next_s == IDLE);
      pending_r  <= (state_next_s == PENDING) || (state_next_s == APPLY);
      updated_r  <= (state_r == APPLY);
    end
  end

  // Shadow bank writes; out-of-range selectors match no entry and are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_IDX; k++) begin
        shadow_r[k] <= '0;
      end
    end else if (transfer_s) begin
      for (int k = 0; k < NUM_IDX; k++) begin
        if (wr_sel == SEL_W'(k)) begin
          shadow_r[k] <= wr_delay;
        end
      end
    end
  end

  // Active bank takes the full shadow bank in one cycle while in APPLY
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r <= '0;
    end else if (state_r == APPLY) begin
      for (int k = 0; k < NUM_IDX; k++) begin
        active_r[k*IDX_W +: IDX_W] <= shadow_r[k];
      end
    end
  end

  assign wr_ready    = wr_ready_r;
  assign pending     = pending_r;
  assign updated     = updated_r;
  assign delay_index = active_r;

`ifdef DELAY_READBACK_EN
  // Combinational AND-OR read mux; an unmatched selector reads zero
  always_comb begin
    rd_shadow = '0;
    rd_active = '0;
    for (int k = 0; k < NUM_IDX; k++) begin
      rd_shadow = rd_shadow | ({IDX_W{rd_sel == SEL_W'(k)}} & shadow_r[k]);
      rd_active = rd_active | ({IDX_W{rd_sel == SEL_W'(k)}} & active_r[k*IDX_W +: IDX_W]);
    end
  end
`else
  // No readback path in this build
`endif

endmodule

// File: tb/tb_delay_index_controller.sv
// Directed self-checking bench for delay_index_controller. The selector is
// widened to 4 bits so that out-of-range indices (e.g. 8) can be driven.
module tb_delay_index_controller;

  localparam int N     = 4;
  localparam int IDX_W = 4;
  localparam int SEL_W = 4;

  logic               clk;
  logic               reset;
  logic               ws;
  logic               wr_valid;
  logic               wr_ready;
  logic [SEL_W-1:0]   wr_sel;
  logic [IDX_W-1:0]   wr_delay;
  logic               wr_commit;
  logic [2*N*IDX_W-1:0] delay_index;
  logic               pending;
  logic               updated;
`ifdef DELAY_READBACK_EN
  logic [SEL_W-1:0]   rd_sel;
  logic [IDX_W-1:0]   rd_shadow;
  logic [IDX_W-1:0]   rd_active;
`endif

  int checks;
  int errors;
  int cyc;
  int upd_cnt;
  int u0;

  delay_index_controller #(
    .NUMBER_OF_CHANNELS (N),
    .BUFFER_SIZE        (16),
    .SEL_W              (SEL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ws          (ws),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_sel      (wr_sel),
    .wr_delay    (wr_delay),
    .wr_commit   (wr_commit),
    .delay_index (delay_index),
    .pending     (pending),
`ifdef DELAY_READBACK_EN
    .rd_sel      (rd_sel),
    .rd_shadow   (rd_shadow),
    .rd_active   (rd_active),
`endif
    .updated     (updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs and ws move 1 time unit after the edge; updated pulses are counted
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ws = ((cyc % 64) < 32);
    upd_cnt += int'(updated);
  endtask

  // Advance until ws has just gone low; the next edge is the detected fall
  task automatic to_prefall();
    while ((cyc % 64) != 32) tick();
  endtask

  // Run through a pending commit's fall and check the apply timing
  task automatic apply_check(input string tag, input logic [31:0] prev, input logic [31:0] exp);
    u0 = upd_cnt;
    to_prefall();
    tick();
    chk({tag, "_F_pending"}, 32'(pending), 32'd1);
    chk({tag, "_F_index"}, delay_index, prev);
    tick();
    chk({tag, "_F1_index"}, delay_index, exp);
    chk({tag, "_F1_pending"}, 32'(pending), 32'd0);
    chk({tag, "_F1_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_F1_updated"}, 32'(updated), 32'd1);
    tick();
    chk({tag, "_F2_updated"}, 32'(updated), 32'd0);
    chk({tag, "_pulse_count"}, 32'(upd_cnt - u0), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; upd_cnt = 0;
    reset = 1'b1; ws = 1'b0; wr_valid = 1'b0; wr_sel = 4'd0; wr_delay = 4'd0; wr_commit = 1'b0;
`ifdef DELAY_READBACK_EN
    rd_sel = 4'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; cyc = 0; ws = 1'b1; upd_cnt = 0;

    // Reset state
    chk("rst_index", delay_index, 32'h0000_0000);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_updated", 32'(updated), 32'd0);

    // Plain write, no commit: active bank untouched over two frames
    wr_valid = 1'b1; wr_sel = 4'd3; wr_delay = 4'd5; wr_commit = 1'b0;
    tick();
    wr_valid = 1'b0;
    chk("wr_ready_after_write", 32'(wr_ready), 32'd1);
`ifdef DELAY_READBACK_EN
    rd_sel = 4'd3;
    #1;
    chk("rd_shadow3", 32'(rd_shadow), 32'd5);
    chk("rd_active3", 32'(rd_active), 32'd0);
    rd_sel = 4'd9;
    #1;
    chk("rd_oob", 32'(rd_shadow), 32'd0);
`endif
    u0 = upd_cnt;
    repeat (128) tick();
    chk("nocommit_index", delay_index, 32'h0000_0000);
    chk("nocommit_updated", 32'(upd_cnt - u0), 32'd0);

    // Write with commit: index0=9 joins index3=5
    wr_valid = 1'b1; wr_sel = 4'd0; wr_delay = 4'd9; wr_commit = 1'b1;
    tick();
    wr_valid = 1'b0; wr_commit = 1'b0;
    chk("commit_pending", 32'(pending), 32'd1);
    chk("commit_ready", 32'(wr_ready), 32'd0);
    apply_check("c1", 32'h0000_0000, 32'h0000_5009);

    // Commit on the same edge as a fall: must wait a whole frame
    to_prefall();
    wr_valid = 1'b1; wr_sel = 4'd1; wr_delay = 4'd7; wr_commit = 1'b1;
    tick();
    wr_valid = 1'b0; wr_commit = 1'b0;
    chk("samefall_pending", 32'(pending), 32'd1);
    u0 = upd_cnt;
    repeat (3) tick();
    chk("samefall_not_applied", delay_index, 32'h0000_5009);
    chk("samefall_no_pulse", 32'(upd_cnt - u0), 32'd0);
    apply_check("c2", 32'h0000_5009, 32'h0000_5079);

    // Write held through PENDING is stalled and lands once ready returns
    wr_valid = 1'b1; wr_sel = 4'd2; wr_delay = 4'd4; wr_commit = 1'b1;
    tick();
    wr_sel = 4'd5; wr_delay = 4'd6; wr_commit = 1'b0;
    tick();
    chk("hold_ready_low", 32'(wr_ready), 32'd0);
    apply_check("c3", 32'h0000_5079, 32'h0000_5479);
    wr_valid = 1'b0;
    chk("hold_ready_after", 32'(wr_ready), 32'd1);

    // Out-of-range write with commit: data dropped, commit honoured
    wr_valid = 1'b1; wr_sel = 4'd8; wr_delay = 4'd15; wr_commit = 1'b1;
    tick();
    wr_valid = 1'b0; wr_commit = 1'b0;
    chk("oob_pending", 32'(pending), 32'd1);
    apply_check("c4", 32'h0000_5479, 32'h0060_5479);

    // Reset while PENDING discards the commit and clears both banks
    wr_valid = 1'b1; wr_sel = 4'd7; wr_delay = 4'd12; wr_commit = 1'b1;
    tick();
    wr_valid = 1'b0; wr_commit = 1'b0;
    chk("rp_pending", 32'(pending), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rp_pending_clr", 32'(pending), 32'd0);
    chk("rp_ready", 32'(wr_ready), 32'd1);
    chk("rp_index", delay_index, 32'h0000_0000);
    u0 = upd_cnt;
    to_prefall();
    repeat (3) tick();
    chk("rp_no_pulse", 32'(upd_cnt - u0), 32'd0);
    chk("rp_index_after_fall", delay_index, 32'h0000_0000);
    wr_valid = 1'b1; wr_sel = 4'd8; wr_delay = 4'd1; wr_commit = 1'b1;
    tick();
    wr_valid = 1'b0; wr_commit = 1'b0;
    apply_check("c5", 32'h0000_0000, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
